// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the byte-loaded APB master bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } bridge_state_e;

    localparam int unsigned TimeoutDefault = 255;
    localparam int unsigned CntW           = 16;

endpackage

// File: rtl/strobe_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse for an asynchronous level strobe.
// The detector arms only after it has seen the strobe low, so a level held through reset is ignored.
module strobe_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_strobe,
    output logic o_pulse
);

    logic [1:0] r_sync;
    logic [1:0] r_fill;
    logic       r_armed;
    logic       r_prev;
    logic       r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_strobe};
            // r_fill[1] marks r_sync[1] as a real sample rather than its reset value
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_sync[1]);
            r_prev  <= r_sync[1];
            r_pulse <= r_armed & r_sync[1] & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/apb_byte_bridge.sv
// APB master bridge: address/data shifted in a byte at a time, transfers launched by strobes.
// Define APB_BRIDGE_AUTOINC_EN to advance the address after each error-free transfer.
module apb_byte_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic [7:0]        data_in,
    input  logic              data_sel,
    input  logic              data_wr,
    input  logic              apb_we,
    input  logic              apb_re,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    logic w_load_ev;
    logic w_we_ev;
    logic w_re_ev;

    strobe_sync_edge u_sync_load (
        .i_clk   (pclk),
        .i_rst_n (prst_n),
        .i_strobe(data_wr),
        .o_pulse (w_load_ev)
    );

    strobe_sync_edge u_sync_we (
        .i_clk   (pclk),
        .i_rst_n (prst_n),
        .i_strobe(apb_we),
        .o_pulse (w_we_ev)
    );

    strobe_sync_edge u_sync_re (
        .i_clk   (pclk),
        .i_rst_n (prst_n),
        .i_strobe(apb_re),
        .o_pulse (w_re_ev)
    );

    bridge_state_e     r_state;
    bridge_state_e     w_state_next;
    logic [CntW-1:0]   r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_data_out;
    logic              r_err;

    logic w_start;
    logic w_timeout;
    logic w_done_ok;
    logic w_done_to;

    assign w_start   = (r_state == StIdle) & (w_we_ev | w_re_ev);
    assign w_timeout = (r_cnt == CntW'(TIMEOUT - 1)) & ~pready;
    assign w_done_ok = (r_state == StAccess) & pready;
    assign w_done_to = (r_state == StAccess) & w_timeout;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_we_ev || w_re_ev) w_state_next = StSetup;
            StSetup:  w_state_next = StAccess;
            StAccess: if (pready || w_timeout) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pwrite   <= 1'b0;
            r_data_out <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_load_ev && data_sel) begin
                r_wdata <= (r_wdata << 8) | DATA_W'(data_in);
            end

            if (w_load_ev && !data_sel) begin
                r_addr <= (r_addr << 8) | ADDR_W'(data_in);
            end
`ifdef APB_BRIDGE_AUTOINC_EN
            else if (w_done_ok && !pslverr) begin
                r_addr <= r_addr + ADDR_W'(DATA_W / 8);
            end
`endif

            // Write wins over a simultaneous read; late strobes are ignored outside IDLE
            if (w_start) begin
                r_err    <= 1'b0;
                r_paddr  <= r_addr;
                r_pwdata <= r_wdata;
                r_pwrite <= w_we_ev;
            end

            if (r_state == StSetup) begin
                r_cnt <= '0;
            end else if (r_state == StAccess) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_done_ok) begin
                r_err <= pslverr;
                if (!r_pwrite) r_data_out <= prdata;
            end else if (w_done_to) begin
                r_err <= 1'b1;
                if (!r_pwrite) r_data_out <= '0;
            end
        end
    end

    assign busy     = (r_state != StIdle);
    assign psel     = busy;
    assign penable  = (r_state == StAccess);
    assign paddr    = r_paddr;
    assign pwrite   = r_pwrite;
    assign pwdata   = r_pwdata;
    assign data_out = r_data_out;
    assign err      = r_err;

endmodule

// File: doc/apb_byte_bridge.md
APB_BYTE_BRIDGE -- requirements
Module: apb_byte_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width; legal values are multiples of 8, from 8 to 32.
REQ-002 Parameter DATA_W, default 8, APB data width; legal values are 8, 16 or 32.
REQ-003 Parameter TIMEOUT, default 255, maximum ACCESS-phase cycles to wait for pready; range 1..65535.
REQ-004 pclk  in  1  sole clock; all logic is on the rising edge.
REQ-005 prst_n  in  1  asynchronous, active-low reset.
REQ-006 data_in  in  8  byte to load into the address or data shift register.
REQ-007 data_sel  in  1  load target: 0 = address, 1 = write data.
REQ-008 data_wr  in  1  byte-load strobe; level input, acts on its rising edge.
REQ-009 apb_we  in  1  write-request strobe; acts on its rising edge.
REQ-010 apb_re  in  1  read-request strobe; acts on its rising edge.
REQ-011 data_out  out  DATA_W  last completed read data.
REQ-012 busy  out  1  high while an APB transfer is in flight.
REQ-013 err  out  1  sticky error: pslverr or timeout; cleared when the next transfer starts.
REQ-014 paddr/psel/penable/pwrite/pwdata  out  ADDR_W/1/1/1/DATA_W  APB master request signals.
REQ-015 prdata/pready/pslverr  in  DATA_W/1/1  APB completer response signals.

Function
REQ-016 data_wr, apb_we and apb_re SHALL each pass a 2-flop synchroniser, then a rising-edge detector; one detected edge is one event, regardless of how long the strobe stays high.
REQ-017 On a data_wr event with data_sel=0: addr_q <= {addr_q[ADDR_W-9:0], data_in}, most-significant byte first; for ADDR_W=8 this is a plain load.
REQ-018 On a data_wr event with data_sel=1: wdata_q shifts the same way, giving {wdata_q[DATA_W-9:0], data_in}.
REQ-019 Byte loads SHALL be accepted in any state; an in-flight transfer uses the paddr/pwdata values captured when it entered SETUP.
REQ-020 FSM states: IDLE, SETUP, ACCESS. IDLE->SETUP on a we/re event; SETUP->ACCESS always; ACCESS->IDLE on pready=1 or on timeout.
REQ-021 A strobe rising edge SHALL produce psel=1 exactly 3 pclk cycles after the first clock edge that samples the strobe high.
REQ-022 SETUP: psel=1, penable=0, paddr/pwrite/pwdata captured. ACCESS: psel=1, penable=1, outputs held stable.
REQ-023 busy=1 in SETUP and ACCESS; busy=0 in IDLE.
REQ-024 A we/re event arriving while busy=1 SHALL be dropped silently.
REQ-025 If we and re events occur in the same cycle, the write SHALL win and the read is dropped.
REQ-026 Read completes with pready=1: data_out <= prdata on the same edge as ACCESS->IDLE; err <= pslverr.
REQ-027 Write completes with pready=1: err <= pslverr; data_out is unchanged.
REQ-028 A 16-bit counter SHALL clear on SETUP and count cycles in ACCESS; if it reaches TIMEOUT with pready=0: go to IDLE, drop psel/penable, set err=1; on a read, data_out <= 0.
REQ-029 err SHALL clear on entry to SETUP.

Reset
REQ-030 While prst_n=0, all of the following SHALL be 0 immediately (asynchronously): psel, penable, pwrite, paddr, pwdata, data_out, busy, err, addr_q, wdata_q, synchroniser flops and counter; FSM = IDLE.
REQ-031 Reset mid-transfer SHALL abort the transfer with no completion side-effects.
REQ-032 A strobe already high at reset release SHALL NOT create an event; the edge-detect flops reset to 0 and must sample a low first.

Configuration
REQ-033 With macro APB_BRIDGE_AUTOINC_EN defined: after each transfer that completes with err=0, addr_q <= addr_q + DATA_W/8, wrapping modulo 2^ADDR_W.
REQ-034 Without APB_BRIDGE_AUTOINC_EN: addr_q changes only on byte loads; repeated accesses target the same address, as needed for FIFO data ports.

Structure
REQ-035 A shared package apb_bridge_pkg SHALL hold the FSM state typedef, the TIMEOUT default and the counter width.
REQ-036 One sub-module, strobe_sync_edge (2-flop synchroniser plus rising-edge pulse), SHALL be instantiated three times.

Verification
REQ-037 Load addr 0x1C, data 0x03, pulse apb_we for 6 cycles -> exactly one APB write (paddr=0x1C, pwdata=0x03, pwrite=1), psel high for 2 cycles with pready=1, err=0.
REQ-038 Read of 0x2C with prdata=0xA5 and pready delayed 3 cycles -> penable held 4 cycles, data_out=0xA5 when busy falls.
REQ-039 pready held at 0 with TIMEOUT=255 -> psel drops after 255 ACCESS cycles, err=1, data_out=0x00; the next apb_we event clears err.
REQ-040 Three apb_re events at addr 0x2C, DATA_W=8 -> paddr 0x2C,0x2D,0x2E with APB_BRIDGE_AUTOINC_EN; 0x2C three times without it.
REQ-041 apb_we and apb_re rising in the same cycle -> one write only; an apb_re edge during busy -> no transfer.
REQ-042 prst_n pulsed low during ACCESS -> psel, penable, busy and err are 0 within the same cycle; no data_out update.
